// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_pkg : shared drain-FSM encoding and constants for uart_tx_fifo
// Revision: 1.0
// ============================================================================
package uart_tx_fifo_pkg;

    localparam int unsigned DATA_W = 8;

    // Cycles (after the launch pulse) to wait for the transmitter to raise busy
    localparam logic [1:0] BUSY_WAIT_MAX = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_if : producer, transmitter and status signals of uart_tx_fifo
// Revision: 1.0
// ============================================================================
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              overflow;

    modport master (
        output in_valid, in_data, flush, tx_busy,
        input  in_ready, tx_start, tx_data, level, empty, overflow
    );

    modport slave (
        input  in_valid, in_data, flush, tx_busy,
        output in_ready, tx_start, tx_data, level, empty, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with wrap-bit pointers and synchronous flush
// Revision: 1.0
// ============================================================================
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WIDTH  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic              flush_i,
    input  wire logic [WIDTH-1:0]  data_i,
    output logic      [WIDTH-1:0]  head_o,
    output logic      [ADDR_W:0]   level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]  wr_q, wr_d;
    logic [ADDR_W:0]  rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Guarded here as well so the FIFO never corrupts itself on a bad request
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[ADDR_W-1:0]] <= data_i;
    end

    assign head_o  = mem_q[rd_q[ADDR_W-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[ADDR_W] != rd_q[ADDR_W]) &&
                     (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]);
    assign level_o = wr_q - rd_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : byte FIFO draining into an RS-232 transmitter start/busy handshake
// Revision: 1.0
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    uart_tx_fifo_if.slave     bus
);
    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              ovf_q, ovf_d;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;

    // A push coinciding with flush is discarded and never counts as overflow
    assign push = bus.in_valid & ~full & ~bus.flush;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .data_i  (bus.in_data),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !bus.tx_busy && !bus.flush) begin
                    pop        = 1'b1;
                    tx_data_d  = head;
                    tx_start_d = 1'b1;
                    cnt_d      = 2'd0;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never acknowledges loses the byte; no replay
                if (bus.tx_busy)                  state_d = ST_WAIT_DONE;
                else if (cnt_q == BUSY_WAIT_MAX)  state_d = ST_IDLE;
                else                              cnt_d   = cnt_q + 2'd1;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (bus.flush)                  ovf_d = 1'b0;
        else if (bus.in_valid && full)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.in_ready = ~full;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.level    = level;
    assign bus.empty    = empty;
    assign bus.overflow = ovf_q;

endmodule
`default_nettype wire
